mux_arbiter: RTL and testbench

Two-requester round-robin arbiter wrapped around a registered 16-bit 2:1 mux. It shares one output channel between requesters 1 and 2 using valid/ready handshakes. It drives the mux select (`addr`) and enforces a bounded burst length so neither requester can starve the other. It sits between two producer blocks and a single downstream consumer, and owns the select timing and the output register.

---
 rtl/mux_arb_pkg.sv | 22 ++
 rtl/mux_out_reg.sv | 36 +++
 rtl/mux_arbiter.sv | 141 ++++++++++++++
 tb/tb_mux_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types for the two-port round-robin mux arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_arb_pkg;

    localparam int WIDTH_DEF     = 16;
    localparam int BURST_MAX_DEF = 4;

    // Arbiter FSM states; value 3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE1 = 2'd1,
        SERVE2 = 2'd2
    } state_t;

    // Encoding of the last-served port, used to break ties from IDLE.
    typedef enum logic {
        PORT1 = 1'b0,
        PORT2 = 1'b1
    } port_t;

endpackage

// File: rtl/mux_out_reg.sv
// Registered 2:1 data mux with load enable; holds the single output beat.
// Latency: one cycle, selected input appears on o_q after the loading edge.
// Backpressure: none internally; the caller gates i_load with its own handshake.
//
// Ports: clk/clr_n (async active-low clear to zero), i_sel (0 = i_d0, 1 = i_d1),
//        i_load (capture selected input), i_d0/i_d1 data in, o_q registered out.
module mux_out_reg
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             i_sel,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d0,
    input  logic [WIDTH-1:0] i_d1,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] w_d;
    logic [WIDTH-1:0] r_q;

    assign w_d = i_sel ? i_d1 : i_d0;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= w_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester round-robin arbiter sharing one registered output channel.
// Latency: one cycle IDLE->SERVE arbitration; accepted beat appears on y the next cycle.
// Backpressure: readies follow (!y_valid | y_ready) for the granted port only; stalls hold state.
//
// Ports: clk, clr_n (async active-low reset);
//        x1_valid/x1/x1_ready and x2_valid/x2/x2_ready requester handshakes;
//        y/y_valid/y_ready downstream handshake;
//        addr (mux select, 1 only in SERVE2); busy (state is not IDLE).
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int BURST_MAX = BURST_MAX_DEF
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             x1_valid,
    input  logic [WIDTH-1:0] x1,
    output logic             x1_ready,
    input  logic             x2_valid,
    input  logic [WIDTH-1:0] x2,
    output logic             x2_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             addr,
    output logic             busy
);

    localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_beat_cnt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] w_cnt_inc;
    port_t      r_last;
    port_t      w_last_nxt;
    logic       r_y_valid;

    logic       w_load_en;
    logic       w_xfer;
    logic       w_own_vld;
    logic       w_oth_vld;
    state_t     w_oth_serve;

    // The output register can take a beat when empty or draining this cycle.
    assign w_load_en = !r_y_valid || y_ready;
    assign x1_ready  = (r_state == SERVE1) && w_load_en;
    assign x2_ready  = (r_state == SERVE2) && w_load_en;
    assign w_xfer    = (x1_valid && x1_ready) || (x2_valid && x2_ready);
    assign w_cnt_inc = r_beat_cnt + 4'd1;

    assign addr    = (r_state == SERVE2);
    assign busy    = (r_state != IDLE);
    assign y_valid = r_y_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_beat_cnt;
        w_last_nxt  = r_last;
        w_own_vld   = 1'b0;
        w_oth_vld   = 1'b0;
        w_oth_serve = IDLE;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = 4'd0;
                if (x1_valid && x2_valid) begin
                    // Tie goes to whichever port was not served last.
                    w_state_nxt = (r_last == PORT1) ? SERVE2 : SERVE1;
                end else if (x1_valid) begin
                    w_state_nxt = SERVE1;
                end else if (x2_valid) begin
                    w_state_nxt = SERVE2;
                end
            end
            SERVE1, SERVE2: begin
                w_own_vld   = (r_state == SERVE1) ? x1_valid : x2_valid;
                w_oth_vld   = (r_state == SERVE1) ? x2_valid : x1_valid;
                w_oth_serve = (r_state == SERVE1) ? SERVE2 : SERVE1;
                if (!w_own_vld) begin
                    // Granted port went away: hand over directly or fall idle.
                    w_cnt_nxt   = 4'd0;
                    w_state_nxt = w_oth_vld ? w_oth_serve : IDLE;
                end else if (w_xfer) begin
                    w_last_nxt = (r_state == SERVE1) ? PORT1 : PORT2;
                    if (w_cnt_inc == BURST_LIM) begin
                        // Burst limit: yield only if the other side is waiting,
                        // otherwise renew the grant with a fresh count.
                        w_cnt_nxt = 4'd0;
                        if (w_oth_vld) begin
                            w_state_nxt = w_oth_serve;
                        end
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= IDLE;
            r_beat_cnt <= 4'd0;
            r_last     <= PORT2;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_cnt_nxt;
            r_last     <= w_last_nxt;
        end
    end

    // A load in the same cycle as a drain keeps the output occupied.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_y_valid <= 1'b0;
        end else if (w_xfer) begin
            r_y_valid <= 1'b1;
        end else if (y_ready) begin
            r_y_valid <= 1'b0;
        end
    end

    mux_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk    (clk),
        .clr_n  (clr_n),
        .i_sel  (addr),
        .i_load (w_xfer),
        .i_d0   (x1),
        .i_d1   (x2),
        .o_q    (y)
    );

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed vector table, hand sequences, random vs model.
// Latency: n/a.
// Backpressure: y_ready driven by the bench.
module tb_mux_arbiter;

    localparam int WIDTH = 16;
    localparam int BMAX  = 4;

    logic             clk = 1'b0;
    logic             clr_n;
    logic             x1_valid;
    logic [WIDTH-1:0] x1;
    logic             x1_ready;
    logic             x2_valid;
    logic [WIDTH-1:0] x2;
    logic             x2_ready;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic             y_ready;
    logic             addr;
    logic             busy;

    always #5 clk = ~clk;

    mux_arbiter #(
        .WIDTH     (WIDTH),
        .BURST_MAX (BMAX)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .x1_valid (x1_valid),
        .x1       (x1),
        .x1_ready (x1_ready),
        .x2_valid (x2_valid),
        .x2       (x2),
        .x2_ready (x2_ready),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .addr     (addr),
        .busy     (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (grant: 0 none, 1 or 2 = port served) ----------------
    int          m_grant;
    int          m_last;
    int          m_cnt;
    logic [15:0] m_y;
    bit          m_yv;

    task automatic model_reset();
        m_grant = 0;
        m_last  = 2;
        m_cnt   = 0;
        m_y     = 16'h0000;
        m_yv    = 1'b0;
    endtask

    task automatic model_check(input string tag);
        bit room;
        room = !m_yv || y_ready;
        check1({tag, ".x1_ready"}, x1_ready, (m_grant == 1) && room);
        check1({tag, ".x2_ready"}, x2_ready, (m_grant == 2) && room);
        check1({tag, ".y_valid"},  y_valid,  m_yv);
        check16({tag, ".y"},       y,        m_y);
        check1({tag, ".addr"},     addr,     m_grant == 2);
        check1({tag, ".busy"},     busy,     m_grant != 0);
    endtask

    task automatic model_step();
        bit          room, vn, vo, took;
        int          n, o;
        logic [15:0] dn;
        room = !m_yv || y_ready;
        if (m_grant == 0) begin
            m_cnt = 0;
            if (y_ready) m_yv = 1'b0;
            if (x1_valid && x2_valid) m_grant = (m_last == 1) ? 2 : 1;
            else if (x1_valid)        m_grant = 1;
            else if (x2_valid)        m_grant = 2;
        end else begin
            n    = m_grant;
            o    = 3 - n;
            vn   = (n == 1) ? x1_valid : x2_valid;
            vo   = (o == 1) ? x1_valid : x2_valid;
            dn   = (n == 1) ? x1 : x2;
            took = vn && room;
            if (took) begin
                m_y    = dn;
                m_yv   = 1'b1;
                m_last = n;
                m_cnt  = m_cnt + 1;
            end else if (y_ready) begin
                m_yv = 1'b0;
            end
            if (!vn) begin
                m_cnt   = 0;
                m_grant = vo ? o : 0;
            end else if (took && m_cnt == BMAX) begin
                m_cnt = 0;
                if (vo) m_grant = o;
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        x1v;
        logic [15:0] x1d;
        logic        x2v;
        logic [15:0] x2d;
        logic        yr;
        logic        e_x1r;
        logic        e_x2r;
        logic        e_yv;
        logic [15:0] e_y;
        logic        e_addr;
        logic        e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic x1v, input logic [15:0] x1d, input logic x2v,
                                input logic [15:0] x2d, input logic yr, input logic e_x1r,
                                input logic e_x2r, input logic e_yv, input logic [15:0] e_y,
                                input logic e_addr, input logic e_busy);
        vec_t v;
        v.x1v = x1v; v.x1d = x1d; v.x2v = x2v; v.x2d = x2d; v.yr = yr;
        v.e_x1r = e_x1r; v.e_x2r = e_x2r; v.e_yv = e_yv; v.e_y = e_y;
        v.e_addr = e_addr; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic do_reset();
        clr_n    = 1'b0;
        x1_valid = 1'b0;
        x2_valid = 1'b0;
        x1       = '0;
        x2       = '0;
        y_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;
        model_reset();
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] cnt_val;
        logic        took;

        // Contention with burst limit 4, then backpressure mid-burst.
        // Columns: x1v x1 x2v x2 yr | x1_ready x2_ready y_valid y addr busy
        tbl.push_back(mk(1, 16'hAAAA, 1, 16'h5555, 1,  0, 0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(1, 16'hAAAA, 1, 16'h5555, 1,  1, 0, 0, 16'h0000, 0, 1));
        tbl.push_back(mk(1, 16'hAAAA, 1, 16'h5555, 1,  1, 0, 1, 16'hAAAA, 0, 1));
        tbl.push_back(mk(1, 16'hAAAA, 1, 16'h5555, 1,  1, 0, 1, 16'hAAAA, 0, 1));
        tbl.push_back(mk(1, 16'hAAAA, 1, 16'h5555, 1,  1, 0, 1, 16'hAAAA, 0, 1));
        tbl.push_back(mk(1, 16'hAAAA, 1, 16'h5555, 1,  0, 1, 1, 16'hAAAA, 1, 1));
        tbl.push_back(mk(1, 16'hAAAA, 1, 16'h5555, 1,  0, 1, 1, 16'h5555, 1, 1));
        tbl.push_back(mk(1, 16'hAAAA, 1, 16'h5555, 1,  0, 1, 1, 16'h5555, 1, 1));
        tbl.push_back(mk(1, 16'hAAAA, 1, 16'h5555, 1,  0, 1, 1, 16'h5555, 1, 1));
        tbl.push_back(mk(1, 16'hAAAA, 1, 16'h5555, 1,  1, 0, 1, 16'h5555, 0, 1));
        tbl.push_back(mk(1, 16'h1234, 1, 16'h5555, 0,  0, 0, 1, 16'hAAAA, 0, 1));
        tbl.push_back(mk(1, 16'h1234, 1, 16'h5555, 0,  0, 0, 1, 16'hAAAA, 0, 1));
        tbl.push_back(mk(1, 16'h1234, 1, 16'h5555, 1,  1, 0, 1, 16'hAAAA, 0, 1));
        tbl.push_back(mk(1, 16'h1234, 1, 16'h5555, 1,  1, 0, 1, 16'h1234, 0, 1));
        tbl.push_back(mk(1, 16'h1234, 1, 16'h5555, 1,  1, 0, 1, 16'h1234, 0, 1));
        tbl.push_back(mk(1, 16'h1234, 1, 16'h5555, 1,  0, 1, 1, 16'h1234, 1, 1));

        // ---- Reset held with toggling inputs ----
        clr_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            x1_valid = 1'($urandom_range(0, 1));
            x2_valid = 1'($urandom_range(0, 1));
            x1       = 16'($urandom);
            x2       = 16'($urandom);
            y_ready  = 1'($urandom_range(0, 1));
            @(negedge clk);
            check1("rst.x1_ready", x1_ready, 1'b0);
            check1("rst.x2_ready", x2_ready, 1'b0);
            check1("rst.y_valid",  y_valid,  1'b0);
            check16("rst.y",       y,        16'h0000);
            check1("rst.addr",     addr,     1'b0);
            check1("rst.busy",     busy,     1'b0);
            next_cycle();
        end
        x1_valid = 1'b0;
        x2_valid = 1'b0;
        clr_n    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("idle.busy",    busy,    1'b0);
            check1("idle.y_valid", y_valid, 1'b0);
            next_cycle();
        end

        // ---- Directed table ----
        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            x1_valid = tbl[i].x1v;
            x1       = tbl[i].x1d;
            x2_valid = tbl[i].x2v;
            x2       = tbl[i].x2d;
            y_ready  = tbl[i].yr;
            @(negedge clk);
            check1($sformatf("tbl%0d.x1_ready", i), x1_ready, tbl[i].e_x1r);
            check1($sformatf("tbl%0d.x2_ready", i), x2_ready, tbl[i].e_x2r);
            check1($sformatf("tbl%0d.y_valid", i),  y_valid,  tbl[i].e_yv);
            check16($sformatf("tbl%0d.y", i),       y,        tbl[i].e_y);
            check1($sformatf("tbl%0d.addr", i),     addr,     tbl[i].e_addr);
            check1($sformatf("tbl%0d.busy", i),     busy,     tbl[i].e_busy);
            next_cycle();
        end

        // ---- Single port streaming, x1 = 1, 2, 3 ... ----
        do_reset();
        x1_valid = 1'b1;
        y_ready  = 1'b1;
        cnt_val  = 16'h0001;
        x1       = cnt_val;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check1($sformatf("strm%0d.x1_ready", c), x1_ready, c != 0);
            check1($sformatf("strm%0d.addr", c), addr, 1'b0);
            if (c >= 2) begin
                check16($sformatf("strm%0d.y", c), y, 16'(c - 1));
                check1($sformatf("strm%0d.y_valid", c), y_valid, 1'b1);
            end
            took = x1_valid && x1_ready;
            next_cycle();
            if (took) begin
                cnt_val = cnt_val + 16'h0001;
                x1      = cnt_val;
            end
        end

        // ---- Port drop in SERVE2, then tie after last = 2 ----
        do_reset();
        y_ready  = 1'b1;
        x2_valid = 1'b1;
        x2       = 16'h0B0B;
        x1       = 16'h0A0A;
        next_cycle();
        @(negedge clk);
        check1("drop.s2_x2_ready", x2_ready, 1'b1);
        check1("drop.s2_addr", addr, 1'b1);
        next_cycle();
        x2_valid = 1'b0;
        x1_valid = 1'b1;
        @(negedge clk);
        check16("drop.y", y, 16'h0B0B);
        next_cycle();
        x1_valid = 1'b0;
        @(negedge clk);
        check1("drop.s1_x1_ready", x1_ready, 1'b1);
        check1("drop.s1_x2_ready", x2_ready, 1'b0);
        check1("drop.s1_addr", addr, 1'b0);
        next_cycle();
        x1_valid = 1'b1;
        x2_valid = 1'b1;
        @(negedge clk);
        check1("drop.idle_busy", busy, 1'b0);
        next_cycle();
        @(negedge clk);
        check1("drop.tie_x1_ready", x1_ready, 1'b1);
        check1("drop.tie_x2_ready", x2_ready, 1'b0);
        check1("drop.tie_addr", addr, 1'b0);

        // ---- Reset pulse during beat 2 of a burst ----
        do_reset();
        y_ready  = 1'b1;
        x1_valid = 1'b1;
        x2_valid = 1'b1;
        x1       = 16'h1111;
        x2       = 16'h2222;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check1("mid.pre_y_valid", y_valid, 1'b1);
        #1 clr_n = 1'b0;
        #1;
        check1("mid.async_y_valid", y_valid, 1'b0);
        check16("mid.async_y", y, 16'h0000);
        check1("mid.async_busy", busy, 1'b0);
        check1("mid.async_x1_ready", x1_ready, 1'b0);
        #1 clr_n = 1'b1;
        #1;
        check1("mid.release_busy", busy, 1'b0);
        next_cycle();
        @(negedge clk);
        check1("mid.tie_x1_ready", x1_ready, 1'b1);
        check1("mid.tie_x2_ready", x2_ready, 1'b0);
        check1("mid.tie_addr", addr, 1'b0);

        // ---- Randomized traffic against the model ----
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            x1_valid = ($urandom_range(0, 3) != 0);
            x2_valid = ($urandom_range(0, 3) != 0);
            x1       = 16'($urandom);
            x2       = 16'($urandom);
            y_ready  = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            model_check($sformatf("rnd%0d", c));
            model_step();
            next_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
